regfile_dumper: RTL and testbench

REGFILE_DUMPER -- requirements
Module: regfile_dumper

---
 rtl/regfile_dumper.sv | 135 +++++++++++++
 tb/tb_regfile_dumper.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dumper.sv
// regfile_dumper: streams all 2**ADDR_W registers out over a valid/ready port.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module regfile_dumper #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic [ADDR_W-1:0] Read_Register_o,
  input  logic [WIDTH-1:0]  Read_Data_i,
  output logic [WIDTH-1:0]  dump_data_o,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic              dump_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
`ifdef REGDUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] rd_reg;
`ifdef REGDUMP_CHECKSUM_EN
  logic [WIDTH-1:0]  csum;
`endif

  assign Read_Register_o = rd_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      rd_reg       <= '0;
      dump_data_o  <= '0;
      dump_addr_o  <= '0;
      dump_valid_o <= 1'b0;
      dump_last_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            idx    <= '0;
            rd_reg <= '0;
            busy_o <= 1'b1;
            state  <= S_READ;
`ifdef REGDUMP_CHECKSUM_EN
            csum   <= '0;
`endif
          end
        end
        S_READ: begin
          dump_data_o  <= Read_Data_i;
          dump_addr_o  <= idx;
          dump_valid_o <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          dump_last_o  <= 1'b0;
`else
          dump_last_o  <= (idx == LAST_IDX);
`endif
          rd_reg       <= '0;
          state        <= S_SEND;
        end
        S_SEND: begin
          if (dump_ready_i) begin
            dump_valid_o <= 1'b0;
            dump_last_o  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum         <= csum ^ dump_data_o;
`endif
            if (idx == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
              // checksum word goes straight out, no extra read cycle
              dump_data_o  <= csum ^ dump_data_o;
              dump_addr_o  <= '0;
              dump_last_o  <= 1'b1;
              dump_valid_o <= 1'b1;
              state        <= S_CSUM;
`else
              done_o       <= 1'b1;
              state        <= S_DONE;
`endif
            end else begin
              idx    <= idx + 1'b1;
              rd_reg <= idx + 1'b1;
              state  <= S_READ;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM: begin
          if (dump_ready_i) begin
            dump_valid_o <= 1'b0;
            dump_last_o  <= 1'b0;
            done_o       <= 1'b1;
            state        <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    dump_valid_o && !dump_ready_i |=> dump_valid_o
      && $stable(dump_data_o) && $stable(dump_addr_o)
      && $stable(dump_last_o));

  assert property (@(posedge clk) disable iff (!rst_n)
    done_o |=> !done_o);

endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper: directed checks of the register dump stream.
// Honours REGDUMP_CHECKSUM_EN to expect the extra checksum word.
module tb_regfile_dumper;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int NW = 33;
`else
  localparam int NW = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  Read_Register_o;
  logic [31:0] Read_Data_i;
  logic [31:0] dump_data_o;
  logic [4:0]  dump_addr_o;
  logic        dump_valid_o;
  logic        dump_ready_i = 1'b0;
  logic        dump_last_o;
  logic        busy_o;
  logic        done_o;

  logic [31:0] rf [32];

  int checks = 0;
  int failures = 0;

  logic [4:0]  got_addr [$];
  logic [31:0] got_data [$];
  bit          got_last [$];
  int          hs_cyc [$];
  int          done_cyc;
  int          unstable;
  int          rr_bad;
  bit          timeout;
  bit          done_after;
  bit          busy_after;
  bit          v_after_rst;
  bit          b_after_rst;

  assign Read_Data_i = rf[Read_Register_o];

  always #5 clk = ~clk;

  regfile_dumper #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .Read_Register_o (Read_Register_o),
    .Read_Data_i     (Read_Data_i),
    .dump_data_o     (dump_data_o),
    .dump_addr_o     (dump_addr_o),
    .dump_valid_o    (dump_valid_o),
    .dump_ready_i    (dump_ready_i),
    .dump_last_o     (dump_last_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mul();
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h11111111;
  endtask

  // Drives one dump and records every handshake; mode selects the scenario.
  task automatic run_dump(input int mode);
    int cyc;
    int hold;
    bit fin;
    bit pstall;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        pl;
    cyc = 0; hold = 0; fin = 0; pstall = 0;
    pa = '0; pd = '0; pl = 1'b0;
    got_addr.delete(); got_data.delete();
    got_last.delete(); hs_cyc.delete();
    done_cyc = -1; unstable = 0; rr_bad = 0; timeout = 0;
    done_after = 1'b1; busy_after = 1'b1;
    start_i = 1'b1;
    dump_ready_i = (mode != 1);
    step();
    start_i = 1'b0;
    while (!fin) begin
      case (mode)
        1: dump_ready_i = (cyc % 4 == 3);
        2: begin
          dump_ready_i = 1'b1;
          start_i = (got_addr.size() == 10);
        end
        3: begin
          if (dump_valid_o && dump_addr_o == 5'd3 && hold < 4) begin
            dump_ready_i = 1'b0;
            hold++;
            if (hold == 2) rf[5] = 32'h5555FFFF;
          end else dump_ready_i = 1'b1;
        end
        default: dump_ready_i = 1'b1;
      endcase
      if (mode == 4 && dump_valid_o && dump_addr_o == 5'd17) begin
        rst_n = 1'b0;
        #1;
        v_after_rst = dump_valid_o;
        b_after_rst = busy_o;
        return;
      end
      if (pstall && (dump_addr_o !== pa || dump_data_o !== pd
          || dump_last_o !== pl || dump_valid_o !== 1'b1))
        unstable++;
      if ((!busy_o || dump_valid_o || done_o) && Read_Register_o !== 5'd0)
        rr_bad++;
      if (dump_valid_o && dump_ready_i) begin
        got_addr.push_back(dump_addr_o);
        got_data.push_back(dump_data_o);
        got_last.push_back(dump_last_o);
        hs_cyc.push_back(cyc);
      end
      pstall = dump_valid_o && !dump_ready_i;
      pa = dump_addr_o; pd = dump_data_o; pl = dump_last_o;
      if (done_o) begin
        done_cyc = cyc;
        start_i = 1'b0;
        step();
        done_after = done_o;
        busy_after = busy_o;
        fin = 1;
      end else begin
        step();
        cyc++;
        if (cyc > 600) begin
          timeout = 1;
          fin = 1;
        end
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; dump_ready_i = 1'b0;
    load_mul();
    step(); step();
    checks++; if (dump_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", dump_valid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done_o); end
    checks++; if (dump_last_o !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", dump_last_o); end
    checks++; if (dump_data_o !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", dump_data_o); end
    checks++; if (dump_addr_o !== 5'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", dump_addr_o); end
    checks++; if (Read_Register_o !== 5'd0) begin failures++; $display("FAIL rst_rdreg got=%0d exp=0", Read_Register_o); end
    rst_n = 1'b1;
    dump_ready_i = 1'b1;
    step(); step(); step();
    checks++; if (busy_o !== 1'b0 || dump_valid_o !== 1'b0) begin failures++; $display("FAIL idle_hold busy=%b valid=%b exp=0/0", busy_o, dump_valid_o); end
  endtask

  task automatic test_full_dump();
    logic [31:0] x;
    load_mul();
    run_dump(0);
    checks++; if (timeout) begin failures++; $display("FAIL full_timeout got=1 exp=0"); end
    checks++; if (got_addr.size() != NW) begin failures++; $display("FAIL full_count got=%0d exp=%0d", got_addr.size(), NW); end
    for (int i = 0; i < 32 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== 5'(i) || got_data[i] !== rf[i]) begin failures++; $display("FAIL full_word%0d got=%0d/%h exp=%0d/%h", i, got_addr[i], got_data[i], i, rf[i]); end
      checks++; if (hs_cyc[i] != 2 * i + 1) begin failures++; $display("FAIL full_rate%0d got=%0d exp=%0d", i, hs_cyc[i], 2 * i + 1); end
    end
    for (int i = 0; i < got_last.size(); i++) begin
      checks++; if (got_last[i] !== (i == NW - 1)) begin failures++; $display("FAIL full_last%0d got=%b exp=%b", i, got_last[i], i == NW - 1); end
    end
`ifdef REGDUMP_CHECKSUM_EN
    x = '0;
    for (int i = 0; i < 32; i++) x ^= rf[i];
    if (got_data.size() == 33) begin
      checks++; if (got_data[32] !== x || got_addr[32] !== 5'd0) begin failures++; $display("FAIL full_csum got=%h/%0d exp=%h/0", got_data[32], got_addr[32], x); end
    end
`else
    x = '0;
`endif
    if (hs_cyc.size() > 0) begin
      checks++; if (done_cyc != hs_cyc[hs_cyc.size() - 1] + 1) begin failures++; $display("FAIL done_time got=%0d exp=%0d", done_cyc, hs_cyc[hs_cyc.size() - 1] + 1); end
    end
    checks++; if (done_after !== 1'b0 || busy_after !== 1'b0) begin failures++; $display("FAIL done_pulse done=%b busy=%b exp=0/0", done_after, busy_after); end
    checks++; if (rr_bad != 0) begin failures++; $display("FAIL rdreg_idle got=%0d exp=0", rr_bad); end
  endtask

  task automatic test_stall();
    load_mul();
    run_dump(1);
    checks++; if (timeout) begin failures++; $display("FAIL stall_timeout got=1 exp=0"); end
    checks++; if (got_addr.size() != NW) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", got_addr.size(), NW); end
    for (int i = 0; i < 32 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== 5'(i) || got_data[i] !== rf[i]) begin failures++; $display("FAIL stall_word%0d got=%0d/%h exp=%0d/%h", i, got_addr[i], got_data[i], i, rf[i]); end
    end
    checks++; if (unstable != 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", unstable); end
  endtask

  task automatic test_restart();
    load_mul();
    run_dump(2);
    checks++; if (timeout) begin failures++; $display("FAIL rs_timeout got=1 exp=0"); end
    checks++; if (got_addr.size() != NW) begin failures++; $display("FAIL rs_count got=%0d exp=%0d", got_addr.size(), NW); end
    for (int i = 0; i < 32 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== 5'(i)) begin failures++; $display("FAIL rs_addr%0d got=%0d exp=%0d", i, got_addr[i], i); end
    end
    step(); step(); step();
    checks++; if (busy_o !== 1'b0 || dump_valid_o !== 1'b0) begin failures++; $display("FAIL rs_noqueue busy=%b valid=%b exp=0/0", busy_o, dump_valid_o); end
  endtask

  task automatic test_live_read();
    load_mul();
    rf[5] = 32'hAAAA0000;
    run_dump(3);
    checks++; if (got_addr.size() != NW) begin failures++; $display("FAIL live_count got=%0d exp=%0d", got_addr.size(), NW); end
    if (got_data.size() > 5) begin
      checks++; if (got_data[5] !== 32'h5555FFFF) begin failures++; $display("FAIL live_r5 got=%h exp=5555ffff", got_data[5]); end
      checks++; if (got_data[4] !== 32'h44444444) begin failures++; $display("FAIL live_r4 got=%h exp=44444444", got_data[4]); end
    end
    checks++; if (unstable != 0) begin failures++; $display("FAIL live_stable got=%0d exp=0", unstable); end
  endtask

  task automatic test_reset_mid();
    load_mul();
    run_dump(4);
    checks++; if (v_after_rst !== 1'b0 || b_after_rst !== 1'b0) begin failures++; $display("FAIL mid_rst valid=%b busy=%b exp=0/0", v_after_rst, b_after_rst); end
    checks++; if (got_addr.size() != 17) begin failures++; $display("FAIL mid_sent got=%0d exp=17", got_addr.size()); end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (busy_o !== 1'b0 || dump_valid_o !== 1'b0) begin failures++; $display("FAIL mid_noresume busy=%b valid=%b exp=0/0", busy_o, dump_valid_o); end
    run_dump(0);
    checks++; if (got_addr.size() != NW) begin failures++; $display("FAIL mid_count got=%0d exp=%0d", got_addr.size(), NW); end
    if (got_addr.size() > 0) begin
      checks++; if (got_addr[0] !== 5'd0 || got_data[0] !== 32'h0) begin failures++; $display("FAIL mid_first got=%0d/%h exp=0/0", got_addr[0], got_data[0]); end
    end
  endtask

  task automatic test_csum();
    for (int i = 0; i < 32; i++) rf[i] = i;
    run_dump(0);
    checks++; if (got_addr.size() != NW) begin failures++; $display("FAIL cs_count got=%0d exp=%0d", got_addr.size(), NW); end
    if (got_addr.size() == NW) begin
`ifdef REGDUMP_CHECKSUM_EN
      checks++; if (got_data[32] !== 32'h0 || got_last[32] !== 1'b1) begin failures++; $display("FAIL cs_word got=%h/%b exp=0/1", got_data[32], got_last[32]); end
      checks++; if (got_last[31] !== 1'b0) begin failures++; $display("FAIL cs_last31 got=%b exp=0", got_last[31]); end
`else
      checks++; if (got_last[31] !== 1'b1 || got_addr[31] !== 5'd31) begin failures++; $display("FAIL cs_last31 got=%b/%0d exp=1/31", got_last[31], got_addr[31]); end
      checks++; if (got_last[30] !== 1'b0 || got_data[31] !== 32'd31) begin failures++; $display("FAIL cs_w31 got=%b/%h exp=0/1f", got_last[30], got_data[31]); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_stall();
    test_restart();
    test_live_read();
    test_reset_mid();
    test_csum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
